// File: rtl/pistorm_pkg.sv
// Shared constants, register map and transaction FSM encoding for the Pi-side
// transaction front end.
package pistorm_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STATUS_RESET   = 1;
    localparam int STATUS_OVERRUN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } txn_state_t;

    // The overrun flag is reported at bit 12 of a status read.
    function automatic logic [15:0] status_read_word(input logic [2:0] ipl,
                                                     input logic       ovr,
                                                     input logic [7:0] cnt);
        return {ipl, ovr, 4'b0000, cnt};
    endfunction

endpackage

// File: rtl/pi_txn_frontend_if.sv
// Pi bus, latch strobes, 68k bus-engine handshake and IPL FIFO signals.
interface pi_txn_frontend_if;
    logic [1:0]  PI_A;
    logic        PI_RD;
    logic        PI_WR;
    logic [15:0] PI_D_IN;
    logic [15:0] PI_D_OUT;
    logic        PI_D_OE;
    logic        LTCH_A_LO;
    logic        LTCH_A_HI;
    logic        LTCH_D_WR;
    logic        LTCH_D_RD_OE_n;
    logic        OP_REQ;
    logic        OP_RW;
    logic        OP_UDS_n;
    logic        OP_LDS_n;
    logic        OP_ACK;
    logic        OP_DONE;
    logic [2:0]  IPL_DATA;
    logic [7:0]  IPL_COUNT;
    logic        IPL_POP;
    logic        TXN_IN_PROGRESS;
    logic        RESET_OUT;

    modport slave (
        input  PI_A, PI_RD, PI_WR, PI_D_IN, OP_ACK, OP_DONE, IPL_DATA, IPL_COUNT,
        output PI_D_OUT, PI_D_OE, LTCH_A_LO, LTCH_A_HI, LTCH_D_WR, LTCH_D_RD_OE_n,
               OP_REQ, OP_RW, OP_UDS_n, OP_LDS_n, IPL_POP, TXN_IN_PROGRESS, RESET_OUT
    );

    modport master (
        output PI_A, PI_RD, PI_WR, PI_D_IN, OP_ACK, OP_DONE, IPL_DATA, IPL_COUNT,
        input  PI_D_OUT, PI_D_OE, LTCH_A_LO, LTCH_A_HI, LTCH_D_WR, LTCH_D_RD_OE_n,
               OP_REQ, OP_RW, OP_UDS_n, OP_LDS_n, IPL_POP, TXN_IN_PROGRESS, RESET_OUT
    );
endinterface

// File: rtl/pi_strobe_sync.sv
// Synchronizes an asynchronous strobe and emits a one-cycle rising-edge pulse.
module pi_strobe_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic [2:0]       arm_q;

    // Edge detection stays masked until the chain and the edge flop have filled,
    // so a strobe already high when reset is released does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= 3'(DEPTH + 1);
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], din};
            prev_q <= sync_q[DEPTH-1];
            if (arm_q != 3'd0)
                arm_q <= arm_q - 3'd1;
        end
    end

    assign rise = sync_q[DEPTH-1] && !prev_q && (arm_q == 3'd0);

endmodule

// File: rtl/pi_txn_frontend.sv
// Pi-side register front end: latch strobes, status register and the
// IDLE->REQ->RUN handshake towards the 68k bus engine.
module pi_txn_frontend
    import pistorm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              PI_CLK,
    input  logic              PI_RST,
    pi_txn_frontend_if.slave  bus
);
    txn_state_t  state_q, state_d;
    logic        rd_rise, wr_rise;
    logic        hi_wr, accept, drop;
    logic        a0_q, txn_q, overrun_q, pop_q;
    logic        rw_q, uds_n_q, lds_n_q;
    logic [15:0] status_q, d_out_q;

    pi_strobe_sync #(.DEPTH(SYNC_STAGES)) u_rd_sync (
        .clk(PI_CLK), .rst(PI_RST), .din(bus.PI_RD), .rise(rd_rise)
    );

    pi_strobe_sync #(.DEPTH(SYNC_STAGES)) u_wr_sync (
        .clk(PI_CLK), .rst(PI_RST), .din(bus.PI_WR), .rise(wr_rise)
    );

    assign bus.LTCH_A_LO      = (bus.PI_A == REG_ADDR_LO) && bus.PI_WR;
    assign bus.LTCH_A_HI      = (bus.PI_A == REG_ADDR_HI) && bus.PI_WR;
    assign bus.LTCH_D_WR      = (bus.PI_A == REG_DATA)    && bus.PI_WR;
    assign bus.LTCH_D_RD_OE_n = !((bus.PI_A == REG_DATA)  && bus.PI_RD);
    assign bus.PI_D_OE        = (bus.PI_A == REG_STATUS)  && bus.PI_RD;

    assign hi_wr = wr_rise && (bus.PI_A == REG_ADDR_HI);

    always_ff @(posedge PI_CLK) begin
        if (PI_RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // An ADDR_HI write is only accepted from IDLE; anywhere else it is an overrun.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hi_wr) begin
                    state_d = ST_REQ;
                    accept  = 1'b1;
                end
            end
            ST_REQ: begin
                drop = hi_wr;
                if (bus.OP_ACK)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                drop = hi_wr;
                if (bus.OP_DONE)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PI_CLK) begin
        if (PI_RST) begin
            a0_q      <= 1'b0;
            txn_q     <= 1'b0;
            overrun_q <= 1'b0;
            rw_q      <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
            status_q  <= 16'h0000;
            d_out_q   <= 16'h0000;
            pop_q     <= 1'b0;
        end else begin
            pop_q <= 1'b0;

            if (wr_rise && (bus.PI_A == REG_ADDR_LO)) begin
                a0_q  <= bus.PI_D_IN[0];
                txn_q <= 1'b1;
            end else if (bus.OP_DONE && (state_q != ST_REQ)) begin
                txn_q <= 1'b0;
            end

            if (accept) begin
                rw_q <= bus.PI_D_IN[9];
                if (bus.PI_D_IN[8]) begin
                    uds_n_q <= a0_q;
                    lds_n_q <= !a0_q;
                end else begin
                    uds_n_q <= 1'b0;
                    lds_n_q <= 1'b0;
                end
            end

            if (drop)
                overrun_q <= 1'b1;
            else if (wr_rise && (bus.PI_A == REG_STATUS) && bus.PI_D_IN[STATUS_OVERRUN])
                overrun_q <= 1'b0;

            if (wr_rise && (bus.PI_A == REG_STATUS)) begin
                status_q                 <= bus.PI_D_IN;
                status_q[STATUS_OVERRUN] <= 1'b0;
            end

            if (rd_rise && (bus.PI_A == REG_STATUS)) begin
                d_out_q <= status_read_word(bus.IPL_DATA, overrun_q, bus.IPL_COUNT);
                pop_q   <= 1'b1;
            end
        end
    end

    assign bus.OP_REQ          = (state_q == ST_REQ);
    assign bus.OP_RW           = rw_q;
    assign bus.OP_UDS_n        = uds_n_q;
    assign bus.OP_LDS_n        = lds_n_q;
    assign bus.TXN_IN_PROGRESS = txn_q;
    assign bus.PI_D_OUT        = d_out_q;
    assign bus.IPL_POP         = pop_q;
    assign bus.RESET_OUT       = !status_q[STATUS_RESET];

endmodule

// File: tb/tb_pi_txn_frontend.sv
// Directed self-checking bench for pi_txn_frontend with SYNC_STAGES = 2.
module tb_pi_txn_frontend;
    logic PI_CLK = 1'b0;
    logic PI_RST;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   pop_cnt;

    pi_txn_frontend_if bus_if ();

    pi_txn_frontend #(.SYNC_STAGES(2)) dut (
        .PI_CLK (PI_CLK),
        .PI_RST (PI_RST),
        .bus    (bus_if.slave)
    );

    always #5 PI_CLK = ~PI_CLK;

    task automatic step(input int n);
        repeat (n) @(posedge PI_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        bus_if.PI_A    = a;
        bus_if.PI_D_IN = d;
        bus_if.PI_WR   = 1'b1;
        step(6);
        bus_if.PI_WR   = 1'b0;
        step(4);
    endtask

    task automatic status_read();
        bus_if.PI_A  = 2'd3;
        bus_if.PI_RD = 1'b1;
        pop_cnt      = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 5) bus_if.PI_RD = 1'b0;
            pop_cnt += int'(bus_if.IPL_POP);
        end
    endtask

    initial begin
        PI_RST            = 1'b1;
        bus_if.PI_A       = 2'd0;
        bus_if.PI_RD      = 1'b0;
        bus_if.PI_WR      = 1'b0;
        bus_if.PI_D_IN    = 16'h0000;
        bus_if.OP_ACK     = 1'b0;
        bus_if.OP_DONE    = 1'b0;
        bus_if.IPL_DATA   = 3'd5;
        bus_if.IPL_COUNT  = 8'h2A;
        step(3);
        check("rst_op_req",  bus_if.OP_REQ, 1'b0);
        check("rst_op_rw",   bus_if.OP_RW, 1'b1);
        check("rst_uds",     bus_if.OP_UDS_n, 1'b1);
        check("rst_lds",     bus_if.OP_LDS_n, 1'b1);
        check("rst_txn",     bus_if.TXN_IN_PROGRESS, 1'b0);
        check("rst_pop",     bus_if.IPL_POP, 1'b0);
        check("rst_dout",    bus_if.PI_D_OUT, 16'h0000);
        check("rst_reset_out", bus_if.RESET_OUT, 1'b1);
        PI_RST = 1'b0;
        step(5);

        // ADDR_LO byte address with a0=1
        bus_if.PI_A = 2'd1; bus_if.PI_D_IN = 16'h0001; bus_if.PI_WR = 1'b1; #1;
        check("ltch_a_lo", bus_if.LTCH_A_LO, 1'b1);
        check("ltch_a_hi_idle", bus_if.LTCH_A_HI, 1'b0);
        check("ltch_d_wr_idle", bus_if.LTCH_D_WR, 1'b0);
        step(6); bus_if.PI_WR = 1'b0; step(4);
        check("txn_after_lo", bus_if.TXN_IN_PROGRESS, 1'b1);

        // ADDR_HI read, byte: OP_REQ exactly three cycles after the pin edge
        bus_if.PI_A = 2'd2; bus_if.PI_D_IN = 16'h0300; bus_if.PI_WR = 1'b1; #1;
        check("ltch_a_hi", bus_if.LTCH_A_HI, 1'b1);
        step(2);
        check("op_req_early", bus_if.OP_REQ, 1'b0);
        step(1);
        check("op_req_rise", bus_if.OP_REQ, 1'b1);
        check("op_rw", bus_if.OP_RW, 1'b1);
        check("op_uds", bus_if.OP_UDS_n, 1'b1);
        check("op_lds", bus_if.OP_LDS_n, 1'b0);
        step(3); bus_if.PI_WR = 1'b0; step(4);

        bus_if.OP_ACK = 1'b1; step(1); bus_if.OP_ACK = 1'b0;
        check("op_req_ack", bus_if.OP_REQ, 1'b0);

        // Overrun: ADDR_HI write in RUN must not alter attributes
        pi_write(2'd2, 16'h0000);
        check("ovr_rw", bus_if.OP_RW, 1'b1);
        check("ovr_uds", bus_if.OP_UDS_n, 1'b1);
        check("ovr_lds", bus_if.OP_LDS_n, 1'b0);
        check("ovr_req", bus_if.OP_REQ, 1'b0);
        check("txn_before_done", bus_if.TXN_IN_PROGRESS, 1'b1);
        bus_if.OP_DONE = 1'b1; step(1); bus_if.OP_DONE = 1'b0;
        check("txn_after_done", bus_if.TXN_IN_PROGRESS, 1'b0);

        status_read();
        check("stat_ovr_word", bus_if.PI_D_OUT, 16'hB02A);
        check("stat_ovr_pops", pop_cnt, 1);
        pi_write(2'd3, 16'h0010);
        status_read();
        check("stat_clear_word", bus_if.PI_D_OUT, 16'hA02A);
        check("stat_clear_pops", pop_cnt, 1);
        check("reset_out_after_clr", bus_if.RESET_OUT, 1'b1);
        bus_if.IPL_DATA = 3'd2; bus_if.IPL_COUNT = 8'h07; step(2);
        check("dout_hold", bus_if.PI_D_OUT, 16'hA02A);

        pi_write(2'd3, 16'h0002);
        check("reset_out_released", bus_if.RESET_OUT, 1'b0);

        bus_if.PI_A = 2'd0; bus_if.PI_RD = 1'b1; #1;
        check("ltch_d_rd_oe_n", bus_if.LTCH_D_RD_OE_n, 1'b0);
        check("pi_d_oe_data", bus_if.PI_D_OE, 1'b0);
        bus_if.PI_RD = 1'b0; bus_if.PI_WR = 1'b1; #1;
        check("ltch_d_wr", bus_if.LTCH_D_WR, 1'b1);
        bus_if.PI_WR = 1'b0; bus_if.PI_A = 2'd3; bus_if.PI_RD = 1'b1; #1;
        check("pi_d_oe_status", bus_if.PI_D_OE, 1'b1);
        check("ltch_rd_oe_n_status", bus_if.LTCH_D_RD_OE_n, 1'b1);
        bus_if.PI_RD = 1'b0; step(8);

        // Word write with a0=0, then reset while in REQ
        pi_write(2'd1, 16'h0000);
        pi_write(2'd2, 16'h0000);
        check("word_req", bus_if.OP_REQ, 1'b1);
        check("word_rw", bus_if.OP_RW, 1'b0);
        check("word_uds", bus_if.OP_UDS_n, 1'b0);
        check("word_lds", bus_if.OP_LDS_n, 1'b0);
        PI_RST = 1'b1; step(1);
        check("mid_rst_req", bus_if.OP_REQ, 1'b0);
        check("mid_rst_rw", bus_if.OP_RW, 1'b1);
        check("mid_rst_uds", bus_if.OP_UDS_n, 1'b1);
        check("mid_rst_lds", bus_if.OP_LDS_n, 1'b1);
        check("mid_rst_txn", bus_if.TXN_IN_PROGRESS, 1'b0);
        check("mid_rst_dout", bus_if.PI_D_OUT, 16'h0000);
        check("mid_rst_reset_out", bus_if.RESET_OUT, 1'b1);
        PI_RST = 1'b0; step(5);

        // ADDR_HI write coinciding with OP_ACK in REQ
        pi_write(2'd1, 16'h0000);
        pi_write(2'd2, 16'h0100);
        check("byte_a0_0_uds", bus_if.OP_UDS_n, 1'b0);
        check("byte_a0_0_lds", bus_if.OP_LDS_n, 1'b1);
        check("byte_a0_0_rw", bus_if.OP_RW, 1'b0);
        bus_if.PI_A = 2'd2; bus_if.PI_D_IN = 16'h0200; bus_if.PI_WR = 1'b1;
        step(2);
        bus_if.OP_ACK = 1'b1; step(1); bus_if.OP_ACK = 1'b0;
        check("coinc_ack_req", bus_if.OP_REQ, 1'b0);
        check("coinc_ack_rw", bus_if.OP_RW, 1'b0);
        bus_if.PI_WR = 1'b0; step(4);
        bus_if.IPL_DATA = 3'd5; bus_if.IPL_COUNT = 8'h2A;
        status_read();
        check("coinc_ack_ovr", bus_if.PI_D_OUT, 16'hB02A);

        // ADDR_LO write coinciding with OP_DONE keeps TXN set
        bus_if.PI_A = 2'd1; bus_if.PI_D_IN = 16'h0001; bus_if.PI_WR = 1'b1;
        step(2);
        bus_if.OP_DONE = 1'b1; step(1); bus_if.OP_DONE = 1'b0;
        check("coinc_done_txn", bus_if.TXN_IN_PROGRESS, 1'b1);
        bus_if.PI_WR = 1'b0; step(4);
        bus_if.OP_DONE = 1'b1; step(1); bus_if.OP_DONE = 1'b0;
        check("idle_done_txn", bus_if.TXN_IN_PROGRESS, 1'b0);
        check("idle_done_req", bus_if.OP_REQ, 1'b0);
        pi_write(2'd2, 16'h0300);
        check("idle_after_done_req", bus_if.OP_REQ, 1'b1);

        // Strobe held high across reset release must not produce an edge
        PI_RST = 1'b1;
        bus_if.PI_A = 2'd1; bus_if.PI_D_IN = 16'h0001; bus_if.PI_WR = 1'b1;
        step(2);
        PI_RST = 1'b0; step(8);
        check("no_spurious_edge", bus_if.TXN_IN_PROGRESS, 1'b0);
        bus_if.PI_WR = 1'b0; step(4);
        pi_write(2'd1, 16'h0000);
        check("first_edge_after_rst", bus_if.TXN_IN_PROGRESS, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pi_txn_frontend.md
PI_TXN_FRONTEND -- requirements
Module: pi_txn_frontend

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for PI_RD and PI_WR. Legal range is 2..4.
REQ-002 Clock is PI_CLK; reset is synchronous and active-high.
REQ-003 PI_CLK  in  1  200 MHz Pi-side clock; the only clock.
REQ-004 PI_RST  in  1  synchronous active-high reset.
REQ-005 PI_A  in  2  register select: 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS.
REQ-006 PI_RD / PI_WR  in  1 each  asynchronous Pi read and write strobes, active high.
REQ-007 PI_D_IN  in  16  Pi data bus input.
REQ-008 PI_D_OUT / PI_D_OE  out  16 / 1  status read data and its output enable.
REQ-009 LTCH_A_LO / LTCH_A_HI / LTCH_D_WR  out  1 each  combinational address and write-data latch strobes.
REQ-010 LTCH_D_RD_OE_n  out  1  combinational read-data latch output enable.
REQ-011 OP_REQ / OP_RW / OP_UDS_n / OP_LDS_n  out  1 each  bus request and attributes sent to the 68k bus engine.
REQ-012 OP_ACK  in  1  one-cycle pulse from the engine (its S1, already synchronized) meaning the request was taken.
REQ-013 OP_DONE  in  1  one-cycle pulse from the engine (its S7, already synchronized) meaning the cycle finished.
REQ-014 IPL_DATA  in  3  head of the IPL FIFO.
REQ-015 IPL_COUNT  in  8  IPL change count.
REQ-016 IPL_POP  out  1  one-cycle pop of the IPL FIFO.
REQ-017 TXN_IN_PROGRESS  out  1  transaction busy flag, drives GPIO0.
REQ-018 RESET_OUT  out  1  bus reset request, equal to !status[1].

Function
REQ-020 PI_RD and PI_WR each pass through a SYNC_STAGES flop chain, then one more flop for edge detection. rd_rise and wr_rise are one-cycle pulses, SYNC_STAGES+1 cycles after the pin edge.
REQ-021 Strobes are combinational on the raw pins:
- LTCH_A_LO = (PI_A==1)&&PI_WR
- LTCH_A_HI = (PI_A==2)&&PI_WR
- LTCH_D_WR = (PI_A==0)&&PI_WR
- LTCH_D_RD_OE_n = !((PI_A==0)&&PI_RD)
- PI_D_OE = (PI_A==3)&&PI_RD
REQ-022 wr_rise with PI_A==1 captures a0=PI_D_IN[0] and sets TXN_IN_PROGRESS.
REQ-023 wr_rise with PI_A==2 while the FSM is IDLE:
- FSM goes IDLE->REQ and OP_REQ=1.
- OP_RW=PI_D_IN[9].
- If PI_D_IN[8]=1 (byte access): OP_UDS_n=a0, OP_LDS_n=!a0.
- Otherwise both are 0.
REQ-024 wr_rise with PI_A==2 while the FSM is not IDLE: the write is dropped, the sticky overrun bit is set, and OP_* is unchanged.
REQ-025 FSM is IDLE->REQ->RUN->IDLE:
- REQ->RUN on OP_ACK; OP_REQ clears in the same cycle.
- RUN->IDLE on OP_DONE; TXN_IN_PROGRESS clears in the same cycle.
- OP_DONE in IDLE clears TXN_IN_PROGRESS only.
REQ-026 OP_RW, OP_UDS_n and OP_LDS_n hold their values from REQ entry until the next accepted ADDR_HI write.
REQ-027 wr_rise with PI_A==3 loads PI_D_IN into status[15:0]. Exception: status[4] is write-1-to-clear overrun and is not stored from the bus.
REQ-028 rd_rise with PI_A==3 loads PI_D_OUT = {IPL_DATA, overrun, 4'b0, IPL_COUNT} and pulses IPL_POP for one cycle.
REQ-029 PI_D_OUT holds its value until the next status read.
REQ-030 If wr_rise and OP_DONE coincide, the ADDR_LO set wins, so TXN_IN_PROGRESS stays 1.
REQ-031 If an ADDR_HI write and OP_ACK coincide in REQ, the ACK is taken and the write counts as an overrun.
REQ-032 If RESET_OUT=1 mid-transaction, the FSM and outputs stay in place. The engine's OP_DONE closes the transaction.

Reset
REQ-040 PI_RST=1 sets the following outputs:
- FSM=IDLE, OP_REQ=0, OP_RW=1, OP_UDS_n=1, OP_LDS_n=1.
- TXN_IN_PROGRESS=0, IPL_POP=0, PI_D_OUT=0.
REQ-041 PI_RST=1 sets the following internal state:
- status=16'h0000, so RESET_OUT=1.
- a0=0, overrun=0, all synchronizer flops 0.
REQ-042 The first edge detect after reset is valid, with no spurious pulse if a pin is already high.

Structure
REQ-050 A shared package pistorm_pkg holds the REG_DATA/ADDR_LO/ADDR_HI/STATUS constants, the FSM state enumeration and the status bit indices (RESET=1, OVERRUN=4).
REQ-051 One sub-module, pi_strobe_sync (parameterised depth, outputs a rising-edge pulse), is instantiated twice.

Verification
REQ-060 ADDR_LO write with D=0x0001, then ADDR_HI write with D=0x0300:
- OP_REQ rises SYNC_STAGES+1 cycles after the PI_WR edge.
- OP_RW=1, OP_UDS_n=1, OP_LDS_n=0.
- TXN_IN_PROGRESS=1.
REQ-061 OP_ACK pulse, then OP_DONE 10 cycles later: OP_REQ drops with the ACK, and TXN_IN_PROGRESS drops with DONE.
REQ-062 Second ADDR_HI write while in RUN:
- overrun=1, OP_* unchanged.
- Status read then returns bit 12=1.
- Writing STATUS with bit 4=1 clears it.
REQ-063 IPL_DATA=3'd5, IPL_COUNT=8'h2A, status read: PI_D_OUT=0xA02A and exactly one IPL_POP pulse.
REQ-064 After reset, RESET_OUT=1; STATUS write 0x0002 sets RESET_OUT=0; PI_RST mid-REQ returns every output to its reset value next cycle.
